// File: rtl/fp4_pkg.sv
// E2M1 (FP4) field definitions, decode to signed quarter-units, and
// fixed-point to FP4 rounding shared by the dot-product MAC.
package fp4_pkg;

  localparam int unsigned E2M1_W = 4;
  localparam int unsigned EXP_W  = 2;
  localparam int unsigned BIAS   = 1;
  localparam int unsigned PROD_W = 9;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic             m;
  } e2m1_t;

  // Quarter-units: subnormal m*0.5 -> 2m; normal (2+m)*2^(e-BIAS) halves -> (2+m)<<e.
  function automatic logic signed [5:0] fp4_decode(input e2m1_t v);
    logic [5:0] mag;
    if (v.e == '0) mag = {4'b0000, v.m, 1'b0};
    else           mag = {4'b0000, 1'b1, v.m} << v.e;
    return v.s ? -$signed(mag) : $signed(mag);
  endfunction

  // q is |fix| in quarters, pre-clamped to 63 (everything >= 21 saturates to 6).
  function automatic logic [3:0] fp4_round(input logic neg, input logic [5:0] q);
    logic [2:0] code;
    if      (q <= 6'd1)  code = 3'd0;
    else if (q == 6'd2)  code = 3'd1;
    else if (q <= 6'd5)  code = 3'd2;
    else if (q == 6'd6)  code = 3'd3;
    else if (q <= 6'd10) code = 3'd4;
    else if (q <= 6'd13) code = 3'd5;
    else if (q <= 6'd20) code = 3'd6;
    else                 code = 3'd7;
    return (code == 3'd0) ? 4'b0000 : {neg, code};
  endfunction

endpackage

// File: rtl/fp4_lane_mul.sv
// One FP4 x FP4 lane: decode both operands and form the exact product
// in signed quarter-units.
module fp4_lane_mul
  import fp4_pkg::*;
(
  input  logic        [E2M1_W-1:0] i_a,
  input  logic        [E2M1_W-1:0] i_b,
  output logic signed [PROD_W-1:0] o_prod
);

  logic signed [5:0]  qa;
  logic signed [5:0]  qb;
  logic signed [11:0] qa_ext;
  logic signed [11:0] qb_ext;
  logic signed [11:0] full;

  // Both decoded values are even, so the /4 back to quarters is exact.
  always_comb begin
    qa     = fp4_decode(e2m1_t'(i_a));
    qb     = fp4_decode(e2m1_t'(i_b));
    qa_ext = qa;
    qb_ext = qb;
    full   = qa_ext * qb_ext;
    o_prod = PROD_W'(full >>> 2);
  end

endmodule

// File: rtl/fp4_dot_mac.sv
// Multi-lane FP4 dot-product MAC: products (S1), lane sum (S2), saturating
// accumulator plus output register (S3), with valid/ready back-pressure.
module fp4_dot_mac
  import fp4_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 24
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  input  logic [4*LANES-1:0]        i_a,
  input  logic [4*LANES-1:0]        i_b,
  input  logic                      i_last,
  output logic                      o_accum_valid,
  input  logic                      i_accum_ready,
  output logic [ACC_W-1:0]          o_accum_fix,
  output logic [3:0]                o_accum_fp4,
  output logic                      o_overflow
);

  localparam int unsigned SUM_W = PROD_W + $clog2(LANES);
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod_w [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic                     v1_q, v1_d, last1_q, last1_d;
  logic signed [SUM_W-1:0]  lane_sum, sum_q, sum_d;
  logic                     v2_q, v2_d, last2_q, last2_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base, acc_sat;
  logic signed [EXT_W-1:0]  acc_wide;
  logic                     acc_ovf;
  logic                     sticky_q, sticky_d, sticky_base;
  logic                     done_q, done_d;
  logic [EXT_W-1:0]         acc_ext, res_mag;
  logic [5:0]               res_mag_c;
  logic                     out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]  out_fix_q, out_fix_d;
  logic [3:0]               out_fp4_q, out_fp4_d;
  logic                     out_ovf_q, out_ovf_d;
  logic                     stall;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp4_lane_mul u_mul (
      .i_a    (i_a[4*k +: 4]),
      .i_b    (i_b[4*k +: 4]),
      .o_prod (prod_w[k])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SUM_W'(prod_q[i]);
    end
  end

  // done_q marks that acc_q holds a finished dot product: it is handed to the
  // output register and the next beat starts from zero in the same cycle.
  always_comb begin
    acc_base    = done_q ? '0 : acc_q;
    sticky_base = done_q ? 1'b0 : sticky_q;
    acc_wide    = EXT_W'(acc_base) + EXT_W'(sum_q);
    acc_ovf     = acc_wide[ACC_W] != acc_wide[ACC_W-1];
    if (acc_ovf) acc_sat = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else         acc_sat = acc_wide[ACC_W-1:0];
    acc_ext     = {acc_q[ACC_W-1], acc_q};
    res_mag     = acc_q[ACC_W-1] ? -acc_ext : acc_ext;
    res_mag_c   = (res_mag > EXT_W'(63)) ? 6'd63 : res_mag[5:0];
  end

  assign stall = out_valid_q && !i_accum_ready;

  always_comb begin
    prod_d      = prod_q;
    v1_d        = v1_q;
    last1_d     = last1_q;
    sum_d       = sum_q;
    v2_d        = v2_q;
    last2_d     = last2_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    out_fix_d   = out_fix_q;
    out_fp4_d   = out_fp4_q;
    out_ovf_d   = out_ovf_q;
    if (!stall) begin
      v1_d    = i_data_valid;
      last1_d = i_last;
      if (i_data_valid) prod_d = prod_w;
      v2_d    = v1_q;
      last2_d = last1_q;
      if (v1_q) sum_d = lane_sum;
      if (v2_q) begin
        acc_d    = acc_sat;
        sticky_d = sticky_base | acc_ovf;
        done_d   = last2_q;
      end else begin
        acc_d    = acc_base;
        sticky_d = sticky_base;
        done_d   = 1'b0;
      end
      out_valid_d = done_q;
      if (done_q) begin
        out_fix_d = acc_q;
        out_fp4_d = fp4_round(acc_q[ACC_W-1], res_mag_c);
        out_ovf_d = sticky_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < LANES; i++) prod_q[i] <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      sum_q       <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_fix_q   <= '0;
      out_fp4_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      sum_q       <= sum_d;
      v2_q        <= v2_d;
      last2_q     <= last2_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_fix_q   <= out_fix_d;
      out_fp4_q   <= out_fp4_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign o_data_ready  = !stall;
  assign o_accum_valid = out_valid_q;
  assign o_accum_fix   = out_fix_q;
  assign o_accum_fp4   = out_fp4_q;
  assign o_overflow    = out_ovf_q;

endmodule

// File: tb/tb_fp4_dot_mac.sv
// Scoreboard bench for fp4_dot_mac: a 24-bit and a 12-bit accumulator
// instance share one stimulus stream and are checked against a behavioural model.
module tb_fp4_dot_mac;

  localparam int LANES = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               data_valid, last, accum_ready;
  logic [4*LANES-1:0] a, b;
  logic               rdy24, v24, ovf24, rdy12, v12, ovf12;
  logic [23:0]        fix24;
  logic [11:0]        fix12;
  logic [3:0]         fp4_24, fp4_12;

  always #5 clk = ~clk;

  fp4_dot_mac #(.LANES(LANES), .ACC_W(24)) dut24 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(data_valid), .o_data_ready(rdy24),
    .i_a(a), .i_b(b), .i_last(last), .o_accum_valid(v24), .i_accum_ready(accum_ready),
    .o_accum_fix(fix24), .o_accum_fp4(fp4_24), .o_overflow(ovf24));

  fp4_dot_mac #(.LANES(LANES), .ACC_W(12)) dut12 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(data_valid), .o_data_ready(rdy12),
    .i_a(a), .i_b(b), .i_last(last), .o_accum_valid(v12), .i_accum_ready(accum_ready),
    .o_accum_fix(fix12), .o_accum_fp4(fp4_12), .o_overflow(ovf12));

  typedef struct {
    longint   fix;
    logic [3:0] fp4;
    logic     ovf;
  } res_t;

  res_t   q24[$], q12[$];
  longint acc24, acc12;
  bit     st24, st12;
  int     n_checks = 0;
  int     n_pass = 0;
  int     bp_mode = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic longint mag_q(input logic [2:0] c);
    case (c)
      3'd0: return 0;   3'd1: return 2;  3'd2: return 4;  3'd3: return 6;
      3'd4: return 8;   3'd5: return 12; 3'd6: return 16; default: return 24;
    endcase
  endfunction

  function automatic longint lane_prod(input logic [3:0] x, input logic [3:0] y);
    longint p;
    p = mag_q(x[2:0]) * mag_q(y[2:0]) / 4;
    return (x[3] ^ y[3]) ? -p : p;
  endfunction

  function automatic logic [3:0] exp_fp4(input longint f);
    longint     q;
    logic [2:0] c;
    q = (f < 0) ? -f : f;
    if      (q <= 1)  c = 0;
    else if (q == 2)  c = 1;
    else if (q <= 5)  c = 2;
    else if (q == 6)  c = 3;
    else if (q <= 10) c = 4;
    else if (q <= 13) c = 5;
    else if (q <= 20) c = 6;
    else              c = 7;
    return (c == 0) ? 4'b0000 : {f < 0, c};
  endfunction

  function automatic longint sat_add(input longint acc, input longint s, input int w,
                                     output bit ovf);
    longint r, mx, mn;
    r  = acc + s;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -(longint'(1) <<< (w - 1));
    ovf = 1'b0;
    if (r > mx) begin r = mx; ovf = 1'b1; end
    if (r < mn) begin r = mn; ovf = 1'b1; end
    return r;
  endfunction

  task automatic drive_beat(input logic [4*LANES-1:0] aa, input logic [4*LANES-1:0] bb,
                            input logic l);
    int     guard;
    longint s;
    bit     o;
    res_t   r;
    @(negedge clk);
    data_valid = 1'b1; a = aa; b = bb; last = l;
    guard = 0;
    while (!(rdy24 && rdy12) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("accept_timeout", 0, 1);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 data_valid = 1'b0;
    s = 0;
    for (int k = 0; k < LANES; k++) s += lane_prod(aa[4*k +: 4], bb[4*k +: 4]);
    acc24 = sat_add(acc24, s, 24, o); st24 |= o;
    acc12 = sat_add(acc12, s, 12, o); st12 |= o;
    if (l) begin
      r.fix = acc24; r.fp4 = exp_fp4(acc24); r.ovf = st24; q24.push_back(r);
      r.fix = acc12; r.fp4 = exp_fp4(acc12); r.ovf = st12; q12.push_back(r);
      acc24 = 0; st24 = 0; acc12 = 0; st12 = 0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((q24.size() != 0 || q12.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain", (q24.size() + q12.size()), 0);
  endtask

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       accum_ready = 1'b1;
      1:       accum_ready = ($urandom_range(0, 9) < 7);
      default: accum_ready = 1'b0;
    endcase
  end

  // Outputs must match the queue head every cycle they are valid, stalled or not.
  always @(negedge clk) begin
    if (!rst) begin
      if (v24) begin
        if (q24.size() == 0) check("unexpected24", 1, 0);
        else begin
          check("fix24", $signed(fix24), q24[0].fix);
          check("fp4_24", fp4_24, q24[0].fp4);
          check("ovf24", ovf24, q24[0].ovf);
          if (accum_ready) void'(q24.pop_front());
        end
      end
      if (v12) begin
        if (q12.size() == 0) check("unexpected12", 1, 0);
        else begin
          check("fix12", $signed(fix12), q12[0].fix);
          check("fp4_12", fp4_12, q12[0].fp4);
          check("ovf12", ovf12, q12[0].ovf);
          if (accum_ready) void'(q12.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; data_valid = 1'b0; last = 1'b0; a = '0; b = '0; accum_ready = 1'b1;
    acc24 = 0; acc12 = 0; st24 = 0; st12 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", v24, 0);
    check("rst_fix", $signed(fix24), 0);
    check("rst_fp4", fp4_24, 0);
    check("rst_ovf", ovf24, 0);
    check("rst_ready", rdy24, 1);
    check("rst_valid12", v12, 0);

    // 1.0 x 1.0 on all lanes, with cycle-accurate latency
    drive_beat(16'h2222, 16'h2222, 1'b1);
    @(posedge clk); #1 check("lat_t1", v24, 0);
    @(posedge clk); #1 check("lat_t2", v24, 0);
    @(posedge clk); #1 check("lat_t3", v24, 1);
    wait_drain();

    drive_beat(16'h0001, 16'h0001, 1'b1);
    drive_beat(16'h0003, 16'h0003, 1'b1);
    wait_drain();

    // back-to-back: two-beat 6x6 then -1x3 with no idle cycle
    drive_beat(16'h7777, 16'h7777, 1'b0);
    drive_beat(16'h7777, 16'h7777, 1'b1);
    drive_beat(16'h000A, 16'h0005, 1'b1);
    wait_drain();

    // saturation on the 12-bit instance, with a bubble, then a clean dot product
    drive_beat(16'h7777, 16'h7777, 1'b0);
    drive_beat(16'h7777, 16'h7777, 1'b0);
    @(negedge clk);
    drive_beat(16'h7777, 16'h7777, 1'b0);
    drive_beat(16'h7777, 16'h7777, 1'b1);
    drive_beat(16'h0002, 16'h0002, 1'b1);
    wait_drain();

    // downstream holds off; upstream must stall, outputs frozen on the head result
    bp_mode = 2;
    fork
      begin
        drive_beat(16'h2222, 16'h2222, 1'b1);
        drive_beat(16'h0003, 16'h0005, 1'b1);
        drive_beat(16'h7777, 16'h9999, 1'b1);
        drive_beat(16'h0101, 16'h0505, 1'b1);
      end
      begin
        int guard;
        guard = 0;
        @(negedge clk);
        while (!v24 && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        check("stall_seen", v24, 1);
        repeat (8) begin
          @(negedge clk);
          check("stall_rdy24", rdy24, 0);
          check("stall_rdy12", rdy12, 0);
        end
        bp_mode = 0;
      end
    join
    wait_drain();

    // random operands, random last flags, bubbles and random back-pressure
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      drive_beat(16'($urandom), 16'($urandom), (i == 39) || ($urandom_range(0, 3) == 0));
    end
    bp_mode = 0;
    wait_drain();

    // reset mid dot product discards the partial sum
    drive_beat(16'h2222, 16'h2222, 1'b0);
    drive_beat(16'h3333, 16'h3333, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    acc24 = 0; acc12 = 0; st24 = 0; st12 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_valid", v24, 0);
    check("mrst_fix", $signed(fix24), 0);
    check("mrst_fp4", fp4_24, 0);
    check("mrst_ovf", ovf24, 0);
    check("mrst_ready", rdy24, 1);
    drive_beat(16'h0002, 16'h0002, 1'b1);
    wait_drain();

    repeat (5) @(negedge clk);
    check("final_valid", v24, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp4_dot_mac.md
# fp4_dot_mac

Parametrised multi-lane FP4 (E2M1) dot-product MAC, the vector successor to the scalar multiply/accumulate top. Each accepted beat carries LANES operand pairs; the products are summed exactly in signed fixed point and accumulated across beats until a beat flagged last. The result is then presented both as a wide fixed-point value and as a rounded FP4 value. Valid/ready handshakes on both sides allow back-pressure from downstream.

## Interface
- LANES, 4: operand pairs per beat; must be ≥1.
- ACC_W, 24: accumulator width in signed quarter-units (LSB = 0.25); must be ≥12.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_data_valid  in  1  beat valid.
- o_data_ready  out  1  block can accept a beat this cycle.
- i_a  in  4*LANES  lane k is i_a[4k+3:4k], E2M1 {s,e[1:0],m}.
- i_b  in  4*LANES  same packing as i_a.
- i_last  in  1  this beat ends the current dot product.
- o_accum_valid  out  1  result valid.
- i_accum_ready  in  1  downstream accepts result.
- o_accum_fix  out  ACC_W  signed result in quarter-units.
- o_accum_fp4  out  4  result rounded to E2M1.
- o_overflow  out  1  accumulator saturated during this dot product.

## Operation
- E2M1 decode, bias 1. e=0 gives m·0.5. e>0 gives (1+m/2)·2^(e−1). The magnitude set is {0,0.5,1,1.5,2,3,4,6}. Both ±0 decode to 0.
- Lane product is exact as a 9-bit signed value in quarter-units, range ±144.
- Lane sum is exact, with width 9+clog2(LANES).
- The accumulator adds each beat's lane sum.
  - It saturates to the signed ACC_W limits.
  - Any saturation sets an internal sticky flag.
- On a last beat, the final accumulated value and sticky flag go to the output register. The accumulator and sticky flag then clear to 0, so the next beat starts a new dot product with no idle cycle.
- FP4 rounding works from |fix| = q quarters, with round-to-nearest, ties-to-even mantissa, and saturation at 6:
  - q≤1 → 0.
  - q=2 → 0.5.
  - 3–5 → 1.
  - 6 → 1.5.
  - 7–10 → 2.
  - 11–13 → 3.
  - 14–20 → 4.
  - ≥21 → 6.
  - The sign is taken from fix. A zero result always encodes 0000, never −0.

## Timing
- Reset values:
  - o_accum_valid=0, o_accum_fix=0, o_accum_fp4=0000, o_overflow=0.
  - Accumulator, sticky flag and all pipeline valids are 0.
  - o_data_ready=1 in the cycle after reset deasserts.
- Pipeline stages:
  - S1 registers the lane products.
  - S2 registers the lane sum.
  - S3 holds the accumulator and output register.
- Latency: a last beat accepted at edge t gives o_accum_valid=1 after edge t+3.
- Throughput: one beat per cycle.
- Stall condition: stall = o_accum_valid && !i_accum_ready.
  - o_data_ready = !stall.
  - While stalled, all stages hold.
  - Outputs are stable while o_accum_valid=1 and i_accum_ready=0.
- A result transfers on o_accum_valid && i_accum_ready.
  - If a new last beat reaches S3 in the same cycle, the output register reloads and o_accum_valid stays 1.
  - Otherwise o_accum_valid drops to 0.
- A beat with i_data_valid=0 inserts a bubble and does not touch the accumulator.
- Asserting i_rst mid-dot-product discards all partial sums and any pending result with no output.

## Structure
- Package fp4_pkg holds:
  - E2M1 field constants.
  - Decode function returning signed quarter-units.
  - Fixed-to-FP4 rounding function.
  - Product width constant PROD_W=9.
- Sub-module fp4_lane_mul: combinational decode plus multiply of one pair into a signed PROD_W product. It is instantiated LANES times.
- Top level holds the S1–S3 registers, the adder tree, the saturating accumulator and the handshake logic.

## Test plan
- LANES=4, all lanes 1.0×1.0 (0010×0010), last=1 → fix=16, fp4=0110, overflow=0, valid 3 cycles after acceptance.
- Lane 0 is 0.5×0.5 (0001×0001), other lanes 0, last=1 → fix=1, fp4=0000 (tie to 0). Repeat with 1.5×1.5, giving 2.25 → fp4=0100.
- Two beats, all lanes 6×6 (0111×0111), last on beat 2 → fix=1152, fp4=0111.
- Next beat back-to-back: lane 0 is −1×3 (1010×0101), last=1 → fix=−12, fp4=1101. This shows the accumulator cleared with no idle cycle.
- ACC_W=12, four beats of all lanes 6×6, last on beat 4 → fix=2047, overflow=1.
  - Next dot product of 1.0×1.0 on one lane → fix=4, overflow=0.
- Hold i_accum_ready=0 with a result pending and keep driving beats:
  - o_data_ready=0 and the outputs stay frozen.
  - Release i_accum_ready → pending results emerge in order with no loss.
- Assert i_rst after two non-last beats → all outputs 0. A fresh dot product then returns only its own sum.
